// File: rtl/mod5_pkg.sv
// Shared types and residue arithmetic for the mod-5 serializer and its checker bench.
package mod5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef logic [2:0] residue_t;

    localparam int MOD5_DIVISOR = 5;
    localparam int GAP_CNT_W    = 4;

    // Appending bit b to a prefix with residue r gives 2r+b, at most 9,
    // so one conditional subtract brings it back into 0..4.
    function automatic residue_t mod5_next(residue_t r, logic b);
        logic [3:0] t;
        t = {r, b};
        if (t >= 4'(MOD5_DIVISOR)) begin
            t = t - 4'(MOD5_DIVISOR);
        end
        return t[2:0];
    endfunction

endpackage

// File: rtl/mod5_serializer_if.sv
// Parallel word input handshake plus framed serial output of the mod-5 serializer.
// slave is the serializer side, master is the word source / serial sink side.
interface mod5_serializer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_dout;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             exp_div;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ser_dout,
        input  ser_valid,
        input  ser_first,
        input  ser_last,
        input  exp_div,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ser_dout,
        output ser_valid,
        output ser_first,
        output ser_last,
        output exp_div,
        output busy
    );
endinterface

// File: rtl/mod5_step.sv
// One residue step r -> (2r+b) mod 5; purely combinational, zero latency, no backpressure.
module mod5_step
    import mod5_pkg::*;
(
    input  residue_t r,
    input  logic     b,
    output residue_t r_next,
    output logic     is_zero
);

    assign r_next  = mod5_next(r, b);
    assign is_zero = (r_next == 3'd0);

endmodule

// File: rtl/mod5_serializer.sv
// MSB-first word serializer with a running mod-5 flag on the LSB; MSB appears one cycle after accept.
// in_ready is held low while shifting (except the LSB cycle when GAP is 0) and for GAP cycles afterwards.
module mod5_serializer
    import mod5_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic              clk,
    input  logic              reset,
    mod5_serializer_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);
    typedef logic [CW-1:0] cnt_t;

    state_t                 state_q,   state_d;
    cnt_t                   bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]       sh_q,      sh_d;
    residue_t               r_q,       r_d;

    logic dout_q,  dout_d;
    logic vld_q,   vld_d;
    logic first_q, first_d;
    logic last_q,  last_d;
    logic div_q,   div_d;

    logic     in_ready;
    logic     accept;
    logic     lsb_now;
    residue_t step_r;
    residue_t step_rn;
    logic     step_b;
    logic     step_zero;

    assign lsb_now  = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
    assign in_ready = !reset && ((state_q == ST_IDLE) || (lsb_now && (GAP == 0)));
    assign accept   = bus.in_valid && in_ready;

    // The residue restarts from zero on accept, so the new word's MSB
    // is folded into a clean residue rather than the previous word's.
    assign step_r = accept ? residue_t'(0) : r_q;
    assign step_b = accept ? bus.in_data[WIDTH-1] : sh_q[WIDTH-1];

    mod5_step u_step (
        .r       (step_r),
        .b       (step_b),
        .r_next  (step_rn),
        .is_zero (step_zero)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sh_d      = sh_q;
        r_d       = r_q;
        dout_d    = 1'b0;
        vld_d     = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        div_d     = 1'b0;

        if (accept) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = cnt_t'(WIDTH - 1);
            sh_d      = bus.in_data << 1;
            r_d       = step_rn;
            dout_d    = step_b;
            vld_d     = 1'b1;
            first_d   = 1'b1;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - cnt_t'(1);
                        sh_d      = sh_q << 1;
                        r_d       = step_rn;
                        dout_d    = step_b;
                        vld_d     = 1'b1;
                        last_d    = (bit_cnt_q == cnt_t'(1));
                        div_d     = (bit_cnt_q == cnt_t'(1)) && step_zero;
                    end else if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GAP_CNT_W'(GAP - 1);
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_d   = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sh_q      <= '0;
            r_q       <= '0;
            dout_q    <= 1'b0;
            vld_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            div_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sh_q      <= sh_d;
            r_q       <= r_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            first_q   <= first_d;
            last_q    <= last_d;
            div_q     <= div_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ser_dout  = dout_q;
    assign bus.ser_valid = vld_q;
    assign bus.ser_first = first_q;
    assign bus.ser_last  = last_q;
    assign bus.exp_div   = div_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mod5_serializer.sv
// Bench for mod5_serializer: directed timing steps plus a frame scoreboard on three configurations.
module tb_mod5_serializer;
    import mod5_pkg::*;

    logic clk;
    logic rst_a, rst_b, rst_c;

    mod5_serializer_if #(.WIDTH(8))  ia ();
    mod5_serializer_if #(.WIDTH(8))  ib ();
    mod5_serializer_if #(.WIDTH(32)) ic ();

    mod5_serializer #(.WIDTH(8),  .GAP(0)) u0 (.clk(clk), .reset(rst_a), .bus(ia));
    mod5_serializer #(.WIDTH(8),  .GAP(2)) u1 (.clk(clk), .reset(rst_b), .bus(ib));
    mod5_serializer #(.WIDTH(32), .GAP(0)) u2 (.clk(clk), .reset(rst_c), .bus(ic));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard: accepted words vs reassembled frames
    logic [31:0] q0[$], q1[$], q2[$];
    logic [2:0]  m_vld, m_dout, m_first, m_last, m_div, m_iv, m_ir, m_rst;
    logic [31:0] m_din [3];
    logic [8:0]  m_r;
    logic [31:0] m_acc [3];
    int          m_nb  [3];
    int          frames[3];
    int          m_w   [3];

    assign m_vld   = {ic.ser_valid, ib.ser_valid, ia.ser_valid};
    assign m_dout  = {ic.ser_dout,  ib.ser_dout,  ia.ser_dout};
    assign m_first = {ic.ser_first, ib.ser_first, ia.ser_first};
    assign m_last  = {ic.ser_last,  ib.ser_last,  ia.ser_last};
    assign m_div   = {ic.exp_div,   ib.exp_div,   ia.exp_div};
    assign m_iv    = {ic.in_valid,  ib.in_valid,  ia.in_valid};
    assign m_ir    = {ic.in_ready,  ib.in_ready,  ia.in_ready};
    assign m_rst   = {rst_c, rst_b, rst_a};
    assign m_din[0] = 32'(ia.in_data);
    assign m_din[1] = 32'(ib.in_data);
    assign m_din[2] = ic.in_data;
    assign m_r     = {u2.r_q, u1.r_q, u0.r_q};

    initial begin
        m_w[0] = 8; m_w[1] = 8; m_w[2] = 32;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = '0; m_nb[i] = 0; frames[i] = 0;
        end
    end

    task automatic push_q(input int i, input logic [31:0] d);
        case (i)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic pop_q(input int i, output logic [31:0] d, output bit ok);
        ok = 1'b0; d = '0;
        case (i)
            0: if (q0.size() > 0) begin d = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin d = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin d = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_rst[i]) begin
                case (i)
                    0: q0.delete();
                    1: q1.delete();
                    default: q2.delete();
                endcase
                m_nb[i] = 0;
            end else begin
                logic [31:0] exp_w;
                bit          ok;
                chk1("r_in_range", m_r[3*i +: 3] <= 3'd4, 1'b1);
                chk1("first_last_excl", m_first[i] && m_last[i], 1'b0);
                if (!m_vld[i]) chk1("dout_idle_zero", m_dout[i], 1'b0);
                if (!m_last[i]) chk1("div_off_lsb", m_div[i], 1'b0);
                if (m_vld[i]) begin
                    if (m_first[i]) begin
                        chkw("first_mid_frame", 32'(m_nb[i]), 32'd0);
                        m_acc[i] = '0;
                        m_nb[i]  = 0;
                    end else begin
                        chk1("bit_without_first", m_nb[i] != 0, 1'b1);
                    end
                    m_acc[i] = (m_acc[i] << 1) | 32'(m_dout[i]);
                    m_nb[i]++;
                    if (m_last[i]) begin
                        pop_q(i, exp_w, ok);
                        chk1("frame_expected", ok, 1'b1);
                        chkw("frame_len", 32'(m_nb[i]), 32'(m_w[i]));
                        chkw("frame_word", m_acc[i], exp_w);
                        chk1("exp_div", m_div[i], (exp_w % MOD5_DIVISOR) == 0);
                        frames[i]++;
                        m_nb[i] = 0;
                    end
                end
                if (m_iv[i] && m_ir[i]) push_q(i, m_din[i]);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_of(input int inst);
        case (inst)
            0: return ia.in_ready;
            1: return ib.in_ready;
            default: return ic.in_ready;
        endcase
    endfunction

    function automatic logic busy_of(input int inst);
        case (inst)
            0: return ia.busy;
            1: return ib.busy;
            default: return ic.busy;
        endcase
    endfunction

    task automatic drive(input int inst, input logic v, input logic [31:0] d);
        case (inst)
            0: begin ia.in_valid = v; ia.in_data = 8'(d); end
            1: begin ib.in_valid = v; ib.in_data = 8'(d); end
            default: begin ic.in_valid = v; ic.in_data = d; end
        endcase
    endtask

    task automatic accept_a(input logic [7:0] w);
        next_cycle();
        drive(0, 1'b1, 32'(w));
        @(negedge clk);
        chk1("a_ready_before_accept", ia.in_ready, 1'b1);
    endtask

    // Checks one 8-bit frame on instance A; optionally presents the next word
    // throughout and, if abort_k is nonzero, hits reset in that bit's cycle.
    task automatic frame_a(input logic [7:0] w, input logic nv, input logic [7:0] nd, input int abort_k);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            drive(0, nv, 32'(nd));
            if (k == abort_k) begin
                rst_a = 1'b1;
                @(negedge clk);
                chkw("a_reset_outputs",
                     32'({ia.ser_valid, ia.ser_dout, ia.ser_first, ia.ser_last,
                          ia.exp_div, ia.in_ready, ia.busy}), 32'd0);
                return;
            end
            @(negedge clk);
            chk1("a_ser_valid", ia.ser_valid, 1'b1);
            chk1("a_ser_dout",  ia.ser_dout,  w[8-k]);
            chk1("a_ser_first", ia.ser_first, k == 1);
            chk1("a_ser_last",  ia.ser_last,  k == 8);
            chk1("a_exp_div",   ia.exp_div,   (k == 8) && ((w % MOD5_DIVISOR) == 0));
            chk1("a_in_ready",  ia.in_ready,  k == 8);
        end
    endtask

    task automatic idle_a();
        next_cycle();
        drive(0, 1'b0, 32'd0);
        @(negedge clk);
        chk1("a_idle_valid", ia.ser_valid, 1'b0);
        chk1("a_idle_ready", ia.in_ready,  1'b1);
        chk1("a_idle_busy",  ia.busy,      1'b0);
    endtask

    task automatic stream(input int inst, input int n, input bit seq);
        int          done   = 0;
        int          budget = 0;
        logic [31:0] w;
        logic        v;
        w = seq ? 32'd0 : $urandom;
        while (done < n && budget < 20000) begin
            next_cycle();
            v = ($urandom_range(0, 3) != 0);
            drive(inst, v, v ? w : $urandom);
            @(negedge clk);
            if (v && ready_of(inst)) begin
                done++;
                w = seq ? 32'(done) : $urandom;
            end
            budget++;
        end
        next_cycle();
        drive(inst, 1'b0, 32'd0);
        chkw("stream_accepted", 32'(done), 32'(n));
    endtask

    task automatic drain(input int inst);
        for (int c = 0; c < 60; c++) begin
            next_cycle();
            @(negedge clk);
            if (!busy_of(inst)) break;
        end
        chk1("drain_idle", busy_of(inst), 1'b0);
    endtask

    // ---------------- directed sequence
    initial begin
        logic [7:0] w1, w2;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ia.in_valid = 1'b1; ia.in_data = 8'hFF;
        ib.in_valid = 1'b0; ib.in_data = '0;
        ic.in_valid = 1'b0; ic.in_data = '0;

        @(negedge clk);
        chkw("reset_outputs_a",
             32'({ia.ser_valid, ia.ser_dout, ia.ser_first, ia.ser_last, ia.exp_div, ia.in_ready, ia.busy}), 32'd0);
        chkw("reset_outputs_b",
             32'({ib.ser_valid, ib.ser_dout, ib.ser_first, ib.ser_last, ib.exp_div, ib.in_ready, ib.busy}), 32'd0);
        chkw("reset_outputs_c",
             32'({ic.ser_valid, ic.ser_dout, ic.ser_first, ic.ser_last, ic.exp_div, ic.in_ready, ic.busy}), 32'd0);

        next_cycle();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ia.in_valid = 1'b0;
        @(negedge clk);
        chk1("a_ready_after_reset", ia.in_ready, 1'b1);

        // single words: divisible, not divisible, all zeros
        accept_a(8'd10); frame_a(8'd10, 1'b0, 8'd0, 0); idle_a();
        accept_a(8'd7);  frame_a(8'd7,  1'b0, 8'd0, 0); idle_a();
        accept_a(8'd0);  frame_a(8'd0,  1'b0, 8'd0, 0); idle_a();

        // back-to-back with in_valid held high
        accept_a(8'hFF);
        frame_a(8'hFF, 1'b1, 8'd3, 0);
        frame_a(8'd3,  1'b0, 8'd0, 0);
        idle_a();

        // reset mid-word, then a clean frame
        accept_a(8'hA5);
        frame_a(8'hA5, 1'b0, 8'd0, 4);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            rst_a = 1'b0;
            @(negedge clk);
            chk1("a_post_abort_valid", ia.ser_valid, 1'b0);
            chk1("a_post_abort_last",  ia.ser_last,  1'b0);
            chk1("a_post_abort_ready", ia.in_ready,  1'b1);
        end
        accept_a(8'd5); frame_a(8'd5, 1'b0, 8'd0, 0); idle_a();

        // exhaustive sweep with random valid drops
        stream(0, 256, 1'b1);
        drain(0);

        // GAP=2: second word waits out the gap
        w1 = 8'd25; w2 = 8'd13;
        next_cycle();
        drive(1, 1'b1, 32'(w1));
        @(negedge clk);
        chk1("b_ready_idle", ib.in_ready, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            drive(1, 1'b1, 32'(w2));
            @(negedge clk);
            chk1("b_ser_valid", ib.ser_valid, 1'b1);
            chk1("b_ser_dout",  ib.ser_dout,  w1[8-k]);
            chk1("b_ser_last",  ib.ser_last,  k == 8);
            chk1("b_in_ready",  ib.in_ready,  1'b0);
        end
        for (int g = 0; g < 2; g++) begin
            next_cycle();
            @(negedge clk);
            chk1("b_gap_valid", ib.ser_valid, 1'b0);
            chk1("b_gap_ready", ib.in_ready,  1'b0);
            chk1("b_gap_busy",  ib.busy,      1'b1);
        end
        next_cycle();
        @(negedge clk);
        chk1("b_idle_ready", ib.in_ready, 1'b1);
        chk1("b_idle_busy",  ib.busy,     1'b0);
        next_cycle();
        drive(1, 1'b0, 32'd0);
        @(negedge clk);
        chk1("b_second_first", ib.ser_first, 1'b1);
        chk1("b_second_msb",   ib.ser_dout,  w2[7]);
        stream(1, 30, 1'b0);
        drain(1);

        // WIDTH=32 random words
        stream(2, 60, 1'b0);
        drain(2);

        chkw("a_frames", 32'(frames[0]), 32'd262);
        chkw("b_frames", 32'(frames[1]), 32'd32);
        chkw("c_frames", 32'(frames[2]), 32'd60);
        chkw("queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
